ir_fusion_filt: RTL
===================

// Module: ir_fusion_filt
// PURPOSE
//  Parametrised IR wall-following heading fusion with per-channel moving-average filtering.
//  Also adds opening debounce, a fill/run state machine, a valid handshake and a saturating output.
//  Sits between the IR sampling front end and the heading PID.
//  Produces dsrd_hdng_adj from dsrd_hdng plus the IR and drift-term correction.
// PARAMETERS
//  IR_W      12      IR reading width (unsigned)
//  HDNG_W    12      heading width (signed)
//  DTRM_W    9       IR_Dtrm width (signed)
//  NOM_IR    12'h900 nominal single-wall IR reading
//  AVG_LOG2  2       log2 of moving-average depth (DEPTH = 2**AVG_LOG2, 1..4)
//  OPN_DB    3       consecutive samples required to change a debounced opening (>=1)
// PORTS
//  clk            in   1       clock, all logic on posedge
//  rst            in   1       asynchronous, active-high reset
//  smpl_vld       in   1       one-cycle strobe: lft_IR/rght_IR/lft_opn/rght_opn are valid
//  lft_IR         in   IR_W    left IR reading
//  rght_IR        in   IR_W    right IR reading
//  lft_opn        in   1       raw left opening flag
//  rght_opn       in   1       raw right opening flag
//  IR_Dtrm        in   DTRM_W  signed drift term
//  en_fusion      in   1       1 = apply correction, 0 = pass dsrd_hdng through
//  dsrd_hdng      in   HDNG_W  signed desired heading
//  dsrd_hdng_adj  out  HDNG_W  signed adjusted heading, registered
//  adj_vld        out  1       one-cycle pulse: dsrd_hdng_adj updated
//  filt_rdy       out  1       1 = averaging window full (RUN state)
// BEHAVIOUR
//  Reset: dsrd_hdng_adj=0, adj_vld=0, filt_rdy=0.
//   Also clears buffers, sums, pointer, fill count and debounce counters; debounced openings=0; state=FILL.
//   Reset asserted mid-operation discards any in-flight sample; no adj_vld follows.
//  Pipeline: smpl_vld at edge N -> stage1 regs (buffers, sums, debounce, state) at N+1.
//   Stage2 then registers dsrd_hdng_adj and pulses adj_vld at N+2.
//   en_fusion and dsrd_hdng are sampled at the stage2 edge.
//   Back-to-back smpl_vld is legal: each sample yields exactly one adj_vld.
//  Debounce, per side: a raw flag differing from the debounced value for OPN_DB consecutive samples flips the debounced value.
//   Any agreeing sample clears that side's counter. The counter advances only on smpl_vld.
//  Filter, per channel: circular buffer of DEPTH entries; wr_ptr wraps DEPTH-1 -> 0.
//   sum (IR_W+AVG_LOG2 bits) is updated as sum += new - buf[wr_ptr]. avg = sum >> AVG_LOG2.
//  FSM FILL: fill_cnt increments per sample; FILL -> RUN when fill_cnt reaches DEPTH. filt_rdy=1 only in RUN.
//  FSM RUN: remains in RUN until flush or reset.
//  Flush: a debounced-opening change on either side zeroes the buffers, sums and pointer and enters FILL.
//   The triggering sample is written as entry 0, so fill_cnt=1 after the flush.
//  IR_adj (signed IR_W):
//   both sides open                -> 0
//   only left open                 -> NOM_IR - avg_r
//   only right open                -> avg_l - NOM_IR
//   neither side open              -> (avg_l - avg_r) >>> 1, computed at IR_W+1 bits
//  corr (HDNG_W+1 bits) = ((sext(IR_Dtrm) <<< 2) + (IR_adj >>> 5)) >>> 1.
//  Output on adj_vld:
//   FILL or en_fusion=0        -> dsrd_hdng
//   otherwise                  -> sat(dsrd_hdng + corr)
//   Saturation clamps to [-2**(HDNG_W-1), 2**(HDNG_W-1)-1].
//  dsrd_hdng_adj holds its value between adj_vld pulses.
// TESTING
//  1. Reset, then 4 samples of lft=0xA00, rght=0x900, no openings, IR_Dtrm=0, dsrd_hdng=0x100, en_fusion=1.
//     -> adj 0x100 x3 with filt_rdy=0, then 0x102 with filt_rdy=1; each adj_vld arrives 2 cycles after smpl_vld.
//  2. In RUN, raw lft_opn=1 for 2 samples then 0 -> no flush, filt_rdy stays 1.
//     Then lft_opn=1 for 3 samples with rght=0x800 -> flush, 3 more samples give passthrough, then 0x104.
//  3. dsrd_hdng=0x7FF, IR_Dtrm=9'h0FF, balanced IR, RUN -> 0x7FF (saturated, no wrap).
//     dsrd_hdng=0x800, IR_Dtrm=9'h100 -> 0x800.
//  4. en_fusion=0 in RUN with IR_Dtrm=9'h010 -> output equals dsrd_hdng; adj_vld still pulses per sample.
//  5. Back-to-back smpl_vld for 8 cycles with lft stepping 0x900..0x970 -> 8 adj_vld pulses.
//     Each output matches a reference model of the window average (check pointer wrap).
//  6. Assert rst between smpl_vld and its adj_vld -> no pulse; outputs 0; filt_rdy=0.
//     The next 3 samples produce passthrough output.

Source files
------------

// File: rtl/ir_fusion_filt.sv
// IR wall-following heading fusion: debounced openings, per-channel moving average,
// fill/run sequencing and a saturated heading correction, two register stages deep.
module ir_fusion_filt #(
  parameter int              IR_W     = 12,
  parameter int              HDNG_W   = 12,
  parameter int              DTRM_W   = 9,
  parameter logic [IR_W-1:0] NOM_IR   = IR_W'(12'h900),
  parameter int              AVG_LOG2 = 2,
  parameter int              OPN_DB   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     smpl_vld,
  input  logic [IR_W-1:0]          lft_IR,
  input  logic [IR_W-1:0]          rght_IR,
  input  logic                     lft_opn,
  input  logic                     rght_opn,
  input  logic signed [DTRM_W-1:0] IR_Dtrm,
  input  logic                     en_fusion,
  input  logic signed [HDNG_W-1:0] dsrd_hdng,
  output logic signed [HDNG_W-1:0] dsrd_hdng_adj,
  output logic                     adj_vld,
  output logic                     filt_rdy
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = IR_W + AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DB_W  = (OPN_DB > 1) ? $clog2(OPN_DB) : 1;

  typedef enum logic {FILL, RUN} state_t;

  logic [IR_W-1:0]          buf_l_q [DEPTH];
  logic [IR_W-1:0]          buf_l_d [DEPTH];
  logic [IR_W-1:0]          buf_r_q [DEPTH];
  logic [IR_W-1:0]          buf_r_d [DEPTH];
  logic [SUM_W-1:0]         sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]         fill_q, fill_d;
  logic [DB_W-1:0]          db_q [2];
  logic [DB_W-1:0]          db_d [2];
  logic                     opn_q [2];
  logic                     opn_d [2];
  state_t                   state_q, state_d;
  logic                     vld_p1_q, vld_p1_d;
  logic signed [HDNG_W-1:0] adj_p2_q, adj_p2_d;
  logic                     vld_p2_q, vld_p2_d;

  logic                     raw_opn [2];
  logic                     flush;
  logic [IR_W-1:0]          avg_l, avg_r;
  logic signed [IR_W-1:0]   ir_adj;
  logic signed [HDNG_W:0]   corr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic signed [IR_W-1:0] ir_adj_f(input logic lo, input logic ro,
                                                      input logic [IR_W-1:0] al,
                                                      input logic [IR_W-1:0] ar);
    logic signed [IR_W:0] l_s, r_s, n_s, d;
    l_s = $signed({1'b0, al});
    r_s = $signed({1'b0, ar});
    n_s = $signed({1'b0, NOM_IR});
    case ({lo, ro})
      2'b11:   d = '0;
      2'b10:   d = n_s - r_s;
      2'b01:   d = l_s - n_s;
      default: d = (l_s - r_s) >>> 1;
    endcase
    return d[IR_W-1:0];
  endfunction

  function automatic logic signed [HDNG_W:0] corr_f(input logic signed [DTRM_W-1:0] dt,
                                                    input logic signed [IR_W-1:0] ia);
    logic signed [HDNG_W:0]   dt_x, ia_x, s;
    logic signed [IR_W-1:0]   ia_sh;
    ia_sh = ia >>> 5;
    dt_x  = (HDNG_W+1)'(dt);
    ia_x  = (HDNG_W+1)'(ia_sh);
    s     = (dt_x <<< 2) + ia_x;
    return s >>> 1;
  endfunction

  function automatic logic signed [HDNG_W-1:0] sat_f(input logic signed [HDNG_W-1:0] h,
                                                     input logic signed [HDNG_W:0] c);
    logic signed [HDNG_W+1:0] s, mx, mn;
    logic signed [HDNG_W-1:0] hmax, hmin;
    hmax = {1'b0, {(HDNG_W-1){1'b1}}};
    hmin = {1'b1, {(HDNG_W-1){1'b0}}};
    mx   = (HDNG_W+2)'(hmax);
    mn   = (HDNG_W+2)'(hmin);
    s    = (HDNG_W+2)'(h) + (HDNG_W+2)'(c);
    if (s > mx)      return hmax;
    else if (s < mn) return hmin;
    else             return s[HDNG_W-1:0];
  endfunction

  assign raw_opn[0] = lft_opn;
  assign raw_opn[1] = rght_opn;

  // Stage 1: debounce, window buffers/sums, fill/run sequencing
  always_comb begin
    buf_l_d  = buf_l_q;
    buf_r_d  = buf_r_q;
    sum_l_d  = sum_l_q;
    sum_r_d  = sum_r_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    db_d     = db_q;
    opn_d    = opn_q;
    state_d  = state_q;
    flush    = 1'b0;
    vld_p1_d = smpl_vld;
    if (smpl_vld) begin
      for (int s = 0; s < 2; s++) begin
        if (raw_opn[s] != opn_q[s]) begin
          if (db_q[s] == DB_W'(OPN_DB - 1)) begin
            opn_d[s] = raw_opn[s];
            db_d[s]  = '0;
          end else begin
            db_d[s] = db_q[s] + 1'b1;
          end
        end else begin
          db_d[s] = '0;
        end
      end
      flush = (opn_d[0] != opn_q[0]) || (opn_d[1] != opn_q[1]);
      if (flush) begin
        // the sample that flips an opening becomes the first entry of a fresh window
        for (int i = 0; i < DEPTH; i++) begin
          buf_l_d[i] = '0;
          buf_r_d[i] = '0;
        end
        buf_l_d[0] = lft_IR;
        buf_r_d[0] = rght_IR;
        sum_l_d    = SUM_W'(lft_IR);
        sum_r_d    = SUM_W'(rght_IR);
        ptr_d      = ptr_inc('0);
        fill_d     = CNT_W'(1);
        state_d    = (DEPTH == 1) ? RUN : FILL;
      end else begin
        buf_l_d[ptr_q] = lft_IR;
        buf_r_d[ptr_q] = rght_IR;
        sum_l_d        = sum_l_q + SUM_W'(lft_IR) - SUM_W'(buf_l_q[ptr_q]);
        sum_r_d        = sum_r_q + SUM_W'(rght_IR) - SUM_W'(buf_r_q[ptr_q]);
        ptr_d          = ptr_inc(ptr_q);
        if (state_q == FILL) begin
          fill_d = fill_q + 1'b1;
          if (fill_d == CNT_W'(DEPTH)) state_d = RUN;
        end
      end
    end
  end

  // Stage 2: heading correction and output register
  always_comb begin
    avg_l    = sum_l_q[SUM_W-1:AVG_LOG2];
    avg_r    = sum_r_q[SUM_W-1:AVG_LOG2];
    ir_adj   = ir_adj_f(opn_q[0], opn_q[1], avg_l, avg_r);
    corr     = corr_f(IR_Dtrm, ir_adj);
    adj_p2_d = adj_p2_q;
    vld_p2_d = vld_p1_q;
    if (vld_p1_q) begin
      adj_p2_d = (state_q == FILL || !en_fusion) ? dsrd_hdng : sat_f(dsrd_hdng, corr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_l_q[i] <= '0;
        buf_r_q[i] <= '0;
      end
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      ptr_q    <= '0;
      fill_q   <= '0;
      db_q[0]  <= '0;
      db_q[1]  <= '0;
      opn_q[0] <= 1'b0;
      opn_q[1] <= 1'b0;
      state_q  <= FILL;
      vld_p1_q <= 1'b0;
      adj_p2_q <= '0;
      vld_p2_q <= 1'b0;
    end else begin
      buf_l_q  <= buf_l_d;
      buf_r_q  <= buf_r_d;
      sum_l_q  <= sum_l_d;
      sum_r_q  <= sum_r_d;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      db_q     <= db_d;
      opn_q    <= opn_d;
      state_q  <= state_d;
      vld_p1_q <= vld_p1_d;
      adj_p2_q <= adj_p2_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  assign dsrd_hdng_adj = adj_p2_q;
  assign adj_vld       = vld_p2_q;
  assign filt_rdy      = (state_q == RUN);

endmodule
